// File: rtl/sea_link_pkg.sv
// Shared types and sizes for the SEA byte-serial link and its output serializer.
package sea_link_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      SEND   = 2'd2
   } link_state_t;

   localparam int HALF_W         = 48;
   localparam int BYTES_PER_HALF = 6;
   localparam int IN_BYTES       = 18;
   localparam int OUT_BYTES      = 12;

   localparam int IN_CNT_W  = 5;
   localparam int OUT_CNT_W = 4;
   localparam int SET_CNT_W = 4;

   localparam int LOAD_W = IN_BYTES * 8;
   localparam int RES_W  = 2 * HALF_W;

endpackage

// File: rtl/sea_byte_ser.sv
// 96-bit parallel-load result register streamed out MSB byte first over valid/ready.
module sea_byte_ser
   import sea_link_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [RES_W-1:0] load_data,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             last
);

   logic [RES_W-1:0]     out_reg;
   logic [OUT_CNT_W-1:0] out_cnt;
   logic                 take;

   assign take     = out_valid & out_ready;
   assign last     = take && (out_cnt == OUT_CNT_W'(OUT_BYTES - 1));
   assign out_data = out_reg[RES_W-1 -: 8];

   // out_reg only moves on a handshake, so out_data holds under back-pressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg   <= '0;
         out_cnt   <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_reg   <= load_data;
         out_cnt   <= '0;
         out_valid <= 1'b1;
      end else if (take) begin
         out_reg <= {out_reg[RES_W-9:0], 8'h00};
         if (last) begin
            out_cnt   <= '0;
            out_valid <= 1'b0;
         end else begin
            out_cnt <= out_cnt + OUT_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sea_byte_link.sv
// Byte-serial front end for the SEA cipher core: 18-byte operand load, settle, 12-byte result stream.
module sea_byte_link
   import sea_link_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HALF_W-1:0] li,
   output logic [HALF_W-1:0] ri,
   output logic [HALF_W-1:0] ki,
   input  logic [HALF_W-1:0] lio,
   input  logic [HALF_W-1:0] rio,
   output logic              busy
);

   link_state_t          state;
   link_state_t          next_state;
   logic [LOAD_W-1:0]    load_reg;
   logic [IN_CNT_W-1:0]  in_cnt;
   logic [SET_CNT_W-1:0] set_cnt;
   logic                 in_take;
   logic                 in_last;
   logic                 settle_done;
   logic                 send_last;

   assign in_take     = in_valid & in_ready;
   assign in_last     = in_take && (in_cnt == IN_CNT_W'(IN_BYTES - 1));
   assign settle_done = (state == SETTLE) && (set_cnt == SET_CNT_W'(SETTLE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         LOAD:    if (in_last)     next_state = SETTLE;
         SETTLE:  if (settle_done) next_state = SEND;
         SEND:    if (send_last)   next_state = LOAD;
         default: next_state = LOAD;
      endcase
   end

   always_comb begin
      in_ready = (state == LOAD);
      busy     = (state != LOAD);
   end

   // The load register only shifts in LOAD, which keeps the core operands frozen while settling.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_reg <= '0;
         in_cnt   <= '0;
         set_cnt  <= '0;
      end else begin
         if (in_take) begin
            load_reg <= {load_reg[LOAD_W-9:0], in_data};
            in_cnt   <= in_last ? '0 : in_cnt + IN_CNT_W'(1);
         end
         if (state == SETTLE) begin
            set_cnt <= settle_done ? '0 : set_cnt + SET_CNT_W'(1);
         end
      end
   end

   assign li = load_reg[LOAD_W-1 -: HALF_W];
   assign ri = load_reg[LOAD_W-HALF_W-1 -: HALF_W];
   assign ki = load_reg[HALF_W-1:0];

   sea_byte_ser u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (settle_done),
      .load_data ({lio, rio}),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .last      (send_last)
   );

endmodule

// File: tb/tb_sea_byte_link.sv
// Bench for sea_byte_link: table vectors, random traffic against a byte-level model, reset and settle corners.
module tb_sea_byte_link;

   typedef logic [7:0] ld_t [18];

   typedef struct {
      int          unit;
      logic [47:0] l;
      logic [47:0] r;
      logic [47:0] k;
      int          mode;
      int          in_gap;
      int          out_stall;
      int          stall_byte;
      logic [95:0] exp_out;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [3];
   logic [7:0]  in_data   [3];
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [7:0]  out_data  [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [47:0] li        [3];
   logic [47:0] ri        [3];
   logic [47:0] ki        [3];
   logic [47:0] lio       [3];
   logic [47:0] rio       [3];
   logic        busy      [3];

   int core_mode;
   int vectors     = 0;
   int miscompares = 0;

   // Stand-in cipher core: 0 = round trip (identity), 1 = inverter, 2 = key mix.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         lio[k] = li[k];
         rio[k] = ri[k];
         if (core_mode == 1) begin
            lio[k] = ~li[k];
            rio[k] = ~ri[k];
         end else if (core_mode == 2) begin
            lio[k] = li[k] ^ ki[k];
            rio[k] = ri[k] ^ {ki[k][23:0], ki[k][47:24]};
         end
      end
   end

   sea_byte_link #(.SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .li(li[0]), .ri(ri[0]), .ki(ki[0]), .lio(lio[0]), .rio(rio[0]), .busy(busy[0]));

   sea_byte_link #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .li(li[1]), .ri(ri[1]), .ki(ki[1]), .lio(lio[1]), .rio(rio[1]), .busy(busy[1]));

   sea_byte_link #(.SETTLE_CYCLES(15)) dut2 (
      .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .li(li[2]), .ri(ri[2]), .ki(ki[2]), .lio(lio[2]), .rio(rio[2]), .busy(busy[2]));

   function automatic int settleOf(input int u);
      return (u == 1) ? 1 : ((u == 2) ? 15 : 2);
   endfunction

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic packBytes(input logic [47:0] l, input logic [47:0] r, input logic [47:0] k, output ld_t b);
      logic [143:0] all;
      all = {l, r, k};
      for (int i = 0; i < 18; i++) b[i] = all[143-8*i -: 8];
   endtask

   // Expected result stream computed from the load bytes alone.
   function automatic logic [95:0] refModel(input ld_t b, input int mode);
      logic [47:0] h [3];
      for (int j = 0; j < 3; j++) begin
         h[j] = '0;
         for (int i = 0; i < 6; i++) h[j] = {h[j][39:0], b[6*j+i]};
      end
      case (mode)
         1:       return {~h[0], ~h[1]};
         2:       return {h[0] ^ h[2], h[1] ^ {h[2][23:0], h[2][47:24]}};
         default: return {h[0], h[1]};
      endcase
   endfunction

   // Drives one transaction cycle by cycle; junk 8'hEE is offered whenever the load is complete.
   task automatic applyStimulus(input int u, input ld_t b, input int in_gap, input int out_stall,
                                input int stall_byte, input int abort_in, input int abort_out,
                                output logic [95:0] res, output int lat, output int viol, output bit timeout);
      int sent, got, cyc, last_acc, first_valid, stall_left;
      bit prev_valid, prev_ready, aborted;
      logic [7:0] prev_data;
      sent = 0; got = 0; cyc = 0; last_acc = -1; first_valid = -1; stall_left = 5;
      prev_valid = 0; prev_ready = 0; prev_data = 8'h00; aborted = 0;
      viol = 0; res = '0;
      while (got < 12 && cyc < 400) begin
         if ((abort_in >= 0 && sent == abort_in) || (abort_out >= 0 && got == abort_out)) begin
            aborted = 1;
            break;
         end
         if (sent < 18) begin
            in_valid[u] = ($urandom_range(99) >= in_gap);
            in_data[u]  = b[sent];
         end else begin
            in_valid[u] = 1'b1;
            in_data[u]  = 8'hEE;
         end
         if (stall_byte == got && out_valid[u] && stall_left > 0) begin
            out_ready[u] = 1'b0;
            stall_left--;
         end else begin
            out_ready[u] = ($urandom_range(99) >= out_stall);
         end
         if (in_ready[u] && out_valid[u]) viol++;
         if (busy[u] !== !in_ready[u]) viol++;
         if (sent < 18 && (!in_ready[u] || out_valid[u])) viol++;
         if (sent == 18 && in_ready[u]) viol++;
         if (prev_valid && !prev_ready && (!out_valid[u] || out_data[u] !== prev_data)) viol++;
         if (in_valid[u] && in_ready[u] && sent < 18) begin
            sent++;
            if (sent == 18) last_acc = cyc;
         end
         if (out_valid[u] && first_valid < 0) first_valid = cyc;
         if (out_valid[u] && out_ready[u]) begin
            res = {res[87:0], out_data[u]};
            got++;
         end
         prev_valid = out_valid[u];
         prev_ready = out_ready[u];
         prev_data  = out_data[u];
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      lat     = first_valid - last_acc;
      timeout = (got < 12) && !aborted;
   endtask

   task automatic checkResetState(input int u, input string tag);
      checkOutput({tag, " in_ready"},  96'(in_ready[u]),  96'(1'b1));
      checkOutput({tag, " out_valid"}, 96'(out_valid[u]), 96'(1'b0));
      checkOutput({tag, " busy"},      96'(busy[u]),      96'(1'b0));
      checkOutput({tag, " out_data"},  96'(out_data[u]),  96'(8'h00));
      checkOutput({tag, " li"},        96'(li[u]),        96'(48'h0));
      checkOutput({tag, " ri"},        96'(ri[u]),        96'(48'h0));
      checkOutput({tag, " ki"},        96'(ki[u]),        96'(48'h0));
   endtask

   task automatic pulseReset(input int u);
      rst[u] = 1'b1;
      @(posedge clk);
      #1;
      rst[u] = 1'b0;
   endtask

   task automatic runVector(input vec_t v, input string tag);
      ld_t b;
      logic [95:0] res;
      int lat, viol;
      bit to;
      core_mode = v.mode;
      packBytes(v.l, v.r, v.k, b);
      applyStimulus(v.unit, b, v.in_gap, v.out_stall, v.stall_byte, -1, -1, res, lat, viol, to);
      checkOutput({tag, " stream"},     res, v.exp_out);
      checkOutput({tag, " latency"},    96'(lat), 96'(settleOf(v.unit) + 1));
      checkOutput({tag, " protocol"},   96'(viol), 96'(0));
      checkOutput({tag, " timeout"},    96'(to), 96'(1'b0));
      checkOutput({tag, " ready_next"}, 96'(in_ready[v.unit]), 96'(1'b1));
      checkOutput({tag, " li"},         96'(li[v.unit]), 96'(v.l));
      checkOutput({tag, " ri"},         96'(ri[v.unit]), 96'(v.r));
      checkOutput({tag, " ki"},         96'(ki[v.unit]), 96'(v.k));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t tbl [5];
      ld_t b;
      logic [95:0] res;
      int lat, viol, mode;
      bit to;

      tbl[0] = '{0, 48'h0123456789AB, 48'hFEDCBA987654, 48'h00112233AABB, 0, 0, 0, -1,
                 96'h0123456789AB_FEDCBA987654};
      tbl[1] = '{0, 48'h000000000000, 48'hFFFFFFFFFFFF, 48'h5A5A5A5A5A5A, 1, 0, 0, -1,
                 96'hFFFFFFFFFFFF_000000000000};
      tbl[2] = '{0, 48'h0123456789AB, 48'hFEDCBA987654, 48'h00112233AABB, 0, 30, 35, 3,
                 96'h0123456789AB_FEDCBA987654};
      tbl[3] = '{1, 48'hA1B2C3D4E5F6, 48'h102030405060, 48'hCAFEF00DBEEF, 0, 0, 0, -1,
                 96'hA1B2C3D4E5F6_102030405060};
      tbl[4] = '{2, 48'h13579BDF0246, 48'h8ACE13579BDF, 48'h0F0F0F0F0F0F, 0, 0, 0, -1,
                 96'h13579BDF0246_8ACE13579BDF};

      core_mode = 0;
      for (int u = 0; u < 3; u++) begin
         rst[u] = 1'b1; in_valid[u] = 1'b0; in_data[u] = 8'h00; out_ready[u] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) rst[u] = 1'b0;
      for (int u = 0; u < 3; u++) checkResetState(u, $sformatf("reset u%0d", u));

      for (int i = 0; i < 5; i++) runVector(tbl[i], $sformatf("tbl%0d", i));

      for (int n = 0; n < 20; n++) begin
         mode = int'($urandom_range(2));
         core_mode = mode;
         for (int i = 0; i < 18; i++) b[i] = 8'($urandom_range(255));
         applyStimulus(0, b, 25, 40, int'($urandom_range(11)), -1, -1, res, lat, viol, to);
         checkOutput($sformatf("rand%0d stream", n), res, refModel(b, mode));
         checkOutput($sformatf("rand%0d latency", n), 96'(lat), 96'(3));
         checkOutput($sformatf("rand%0d protocol", n), 96'(viol), 96'(0));
         checkOutput($sformatf("rand%0d timeout", n), 96'(to), 96'(1'b0));
         checkOutput($sformatf("rand%0d li", n), 96'(li[0]), 96'(refModel(b, 0) >> 48));
      end

      core_mode = 0;
      packBytes(tbl[0].l, tbl[0].r, tbl[0].k, b);
      applyStimulus(0, b, 0, 0, -1, 9, -1, res, lat, viol, to);
      pulseReset(0);
      checkResetState(0, "rst mid-load");
      runVector(tbl[0], "after load reset");

      applyStimulus(0, b, 0, 0, -1, -1, 4, res, lat, viol, to);
      checkOutput("partial stream", res, 96'h01234567);
      pulseReset(0);
      checkResetState(0, "rst mid-send");
      runVector(tbl[1], "after send reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sea_byte_link.md
# sea_byte_link

Byte-serial front end for the 48-bit-half SEA cipher datapath. It accepts an 18-byte load stream (left half, right half, key) over an 8-bit valid/ready port and drives it in parallel onto the combinational cipher's `li`/`ri`/`ki` inputs. After a fixed settle time it captures the 96-bit `lio`/`rio` result and returns it as a 12-byte stream over a second valid/ready port. It sits between the pad-limited tapeout I/O and the wide `sea_en`/`sea_de` core.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the core inputs are held stable before capture; legal range 1..15.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: load byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: link accepts a byte this cycle.
- `out_data` output 8: result byte.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer takes `out_data` this cycle.
- `li`, `ri`, `ki` output 48 each: registered operands to the cipher core.
- `lio`, `rio` input 48 each: core result, sampled only at capture.
- `busy` output 1: high in SETTLE and SEND.

## Operation
- States: LOAD, SETTLE, SEND. Reset state is LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready` at an edge) shifts `in_data` into a 144-bit load register and increments `in_cnt` (0..17).
  - Byte order is MSB-first: bytes 0–5 form `li[47:0]`, with byte 0 as `li[47:40]`. Bytes 6–11 form `ri`. Bytes 12–17 form `ki`.
  - `li`/`ri`/`ki` are driven directly from the load register. They change during LOAD and are frozen outside LOAD.
  - The handshake on byte 17 clears `in_cnt` and moves to SETTLE.
- **SETTLE**
  - `in_ready`=0.
  - `set_cnt` counts 0..SETTLE_CYCLES-1.
  - On the edge ending the cycle where `set_cnt`=SETTLE_CYCLES-1, `{lio,rio}` is captured into the 96-bit output register, `out_cnt` is cleared, and the state moves to SEND.
- **SEND**
  - `out_valid`=1.
  - `out_data`=`out_reg[95:88]`.
  - Each handshake shifts `out_reg` left by 8 and increments `out_cnt` (0..11).
  - Output order: `lio[47:40]` first, then through `lio[7:0]`, then `rio[47:40]` through `rio[7:0]`.
  - The handshake on byte 11 returns the state to LOAD.
- Load and result streams never overlap. `in_ready` and `out_valid` are never both high.
- Back-pressure:
  - `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
  - `in_valid` with `in_ready`=0 is ignored; no byte is lost or duplicated.
- Counter widths: `in_cnt` 5 bits, `out_cnt` 4 bits, `set_cnt` 4 bits. No wrap occurs inside the legal ranges.
- Reset mid-operation, from any state:
  - State goes to LOAD; all counters are cleared.
  - The load register, `out_reg`, `li`, `ri` and `ki` are cleared to 0.
  - Any partial stream is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=8'h00, `li`=`ri`=`ki`=48'h0.
- The link supports one byte per cycle on each port when the peer is always valid/ready.
- Last load byte accepted at the edge ending cycle c:
  - SETTLE occupies cycles c+1..c+SETTLE_CYCLES.
  - Capture happens on the edge ending cycle c+SETTLE_CYCLES.
  - `out_valid` is first high in cycle c+SETTLE_CYCLES+1.
- Final output byte accepted at the edge ending cycle d: `in_ready`=1 in cycle d+1.
- Minimum transaction length is 18 + SETTLE_CYCLES + 12 cycles.
- `li`/`ri`/`ki` are stable for all of SETTLE. The core path `li`→`lio` must meet SETTLE_CYCLES·Tclk.
- `out_data`, `out_valid`, `in_ready` and `busy` are register or state-decoded outputs. There are no combinational paths from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `sea_link_pkg` holds:
  - the state enum (LOAD, SETTLE, SEND);
  - `HALF_W`=48, `BYTES_PER_HALF`=6, `IN_BYTES`=18, `OUT_BYTES`=12;
  - the counter widths.
- One natural sub-module, `sea_byte_ser`: the 96-bit parallel-load, byte-shift output register with `out_cnt`, `out_valid` and the ready handshake.
- Top-level integration instantiates `sea_byte_link` in front of the existing round-trip core: `li`/`ri`/`ki` go to the core, and `lio`/`rio` come back.

## Test plan
- **Round trip through `sea_en`→`sea_de`.** Stimulus: load `li`=48'h0123456789AB, `ri`=48'hFEDCBA987654, `ki`=48'h00112233AABB, SETTLE_CYCLES=2. Required response: 12 output bytes 01 23 45 67 89 AB FE DC BA 98 76 54, with `out_valid` first high exactly 3 cycles after the 18th accept.
- **Inverting stub core.** Stimulus: stub with `lio`=~`li`, `rio`=~`ri`; `li`=48'h0, `ri`=48'hFFFFFFFFFFFF. Required response: output bytes are six FF then six 00.
- **Random stalls.** Stimulus: random `in_valid` gaps and random `out_ready` deassertion, including `out_ready`=0 for 5 cycles on byte 3. Required response: `out_data` holds steady during the stall, the stream is identical to the no-stall run, and `in_ready`=0 throughout SETTLE and SEND.
- **Ignored input outside LOAD.** Stimulus: `in_valid` held high during SETTLE/SEND with junk 8'hEE. Required response: the byte is ignored and the next transaction loads correctly.
- **Reset mid-operation.** Stimulus: assert `rst` for 1 cycle after 9 load bytes. Then assert it again during SEND after 4 output bytes. Required response: `in_ready`=1, `out_valid`=0 and `li`/`ri`/`ki`=0 next cycle; a fresh 18-byte load then completes normally.
- **Settle boundary.** Stimulus: SETTLE_CYCLES=1 and SETTLE_CYCLES=15. Required response: `out_valid` rises 2 and 16 cycles after the last accept, respectively.
